load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response signals and data-memory bus of the load/store unit.
// master = the load/store unit itself, slave = the core/memory environment around it.
interface load_store_unit_if;
  logic        valid_i;
  logic        load_i;
  logic        store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        busy_o;
  logic        done_o;
  logic        fault_o;
  logic [31:0] load_data_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    input  valid_i, load_i, store_i, funct3_i, addr_i, store_data_i,
           dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output busy_o, done_o, fault_o, load_data_o,
           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
  );

  modport slave (
    output valid_i, load_i, store_i, funct3_i, addr_i, store_data_i,
           dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  busy_o, done_o, fault_o, load_data_o,
           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-access load/store unit: aligns/checks a core access, runs one data-memory
// request with grant/rvalid timeout, and formats load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk_i,
  input logic               rst_n_i,
  load_store_unit_if.master lsu
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic [2:0]  r_funct3;
  logic [3:0]  r_be;
  logic        r_store;
  logic        r_fault;
  logic [7:0]  r_cnt;
  logic        w_accept;
  logic        w_legal;
  logic        w_timeout;

  function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] a, input logic st);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return ~a[0];
      3'b010:  return (a == 2'b00);
      3'b100:  return ~st;
      3'b101:  return ~st & ~a[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Lane select by byte offset, then sign- or zero-extend according to funct3.
  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  assign w_accept  = lsu.valid_i & (lsu.load_i | lsu.store_i);
  assign w_legal   = is_legal(lsu.funct3_i, lsu.addr_i[1:0], lsu.store_i);
  assign w_timeout = (r_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_legal ? S_REQ : S_DONE;
      S_REQ: begin
        if (lsu.dmem_gnt_i) w_next = r_store ? S_DONE : S_WAIT;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WAIT: if (lsu.dmem_rvalid_i || w_timeout) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Access context is captured once at accept; the counter restarts on every REQ/WAIT entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr      <= '0;
      r_funct3    <= '0;
      r_store     <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= lsu.addr_i;
            r_funct3 <= lsu.funct3_i;
            r_store  <= lsu.store_i;
            r_wdata  <= lane_wdata(lsu.funct3_i, lsu.store_data_i);
            r_be     <= lane_be(lsu.funct3_i, lsu.addr_i[1:0]);
            r_fault  <= ~w_legal;
            r_cnt    <= '0;
          end
        end
        S_REQ: begin
          if (lsu.dmem_gnt_i) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) r_fault <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lsu.dmem_rvalid_i) begin
            r_load_data <= fmt_load(lsu.dmem_rdata_i, r_addr[1:0], r_funct3);
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) r_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lsu.busy_o       = (r_state != S_IDLE);
    lsu.done_o       = (r_state == S_DONE);
    lsu.fault_o      = (r_state == S_DONE) & r_fault;
    lsu.dmem_req_o   = (r_state == S_REQ);
    lsu.dmem_we_o    = (r_state == S_REQ) & r_store;
    lsu.dmem_addr_o  = {r_addr[31:2], 2'b00};
    lsu.dmem_be_o    = r_be;
    lsu.dmem_wdata_o = r_wdata;
    lsu.load_data_o  = r_load_data;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: completions are scored against a queue of
// expected {fault, load_data} entries pushed when each access is issued.
module tb_load_store_unit;
  typedef struct {
    string       tag;
    logic        fault;
    logic [31:0] ld;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          n_cmp;
  int          n_err;
  exp_t        sb_q[$];
  logic [31:0] model_ld;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .lsu     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion scoreboard: every done_o must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done_o === 1'b1) begin
        chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.tag, "_fault"}, 32'(bus.fault_o), 32'(e.fault));
          chk({e.tag, "_ldata"}, bus.load_data_o, e.ld);
        end
      end else begin
        chk("fault_outside_done", 32'(bus.fault_o), 32'd0);
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bus.valid_i      = 1'b1;
    bus.load_i       = ld;
    bus.store_i      = st;
    bus.funct3_i     = f3;
    bus.addr_i       = a;
    bus.store_data_i = d;
  endtask

  task automatic idle_inputs();
    bus.valid_i      = 1'b0;
    bus.load_i       = 1'b0;
    bus.store_i      = 1'b0;
    bus.funct3_i     = 3'b111;
    bus.addr_i       = 32'hFFFF_FFFF;
    bus.store_data_i = 32'hFFFF_FFFF;
  endtask

  task automatic do_access(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input int gdly,
                           input logic [31:0] rd, input logic [3:0] xbe,
                           input logic [31:0] xwd, input logic [31:0] xld);
    drive(ld, st, f3, a, d);
    if (!st) model_ld = xld;
    sb_q.push_back('{tag, 1'b0, model_ld});
    step();
    idle_inputs();
    for (int i = 0; i <= gdly; i++) begin
      chk({tag, "_req"},   32'(bus.dmem_req_o), 32'd1);
      chk({tag, "_we"},    32'(bus.dmem_we_o), 32'(st));
      chk({tag, "_be"},    32'(bus.dmem_be_o), 32'(xbe));
      chk({tag, "_addr"},  bus.dmem_addr_o, {a[31:2], 2'b00});
      chk({tag, "_wdata"}, bus.dmem_wdata_o, xwd);
      if (i == gdly) bus.dmem_gnt_i = 1'b1;
      step();
      bus.dmem_gnt_i = 1'b0;
    end
    if (!st) begin
      chk({tag, "_wait_busy"}, 32'(bus.busy_o), 32'd1);
      chk({tag, "_wait_req"},  32'(bus.dmem_req_o), 32'd0);
      chk({tag, "_wait_done"}, 32'(bus.done_o), 32'd0);
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i  = rd;
      step();
      bus.dmem_rvalid_i = 1'b0;
      bus.dmem_rdata_i  = 32'h0;
    end
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    step();
    chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic do_illegal(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a);
    drive(ld, st, f3, a, 32'h5555_AAAA);
    sb_q.push_back('{tag, 1'b1, model_ld});
    step();
    idle_inputs();
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_req"},  32'(bus.dmem_req_o), 32'd0);
    step();
    chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    model_ld = 32'h0;
    rst_n    = 1'b0;
    idle_inputs();
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = 32'h0;

    #3;
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_done",  32'(bus.done_o), 32'd0);
    chk("rst_fault", 32'(bus.fault_o), 32'd0);
    chk("rst_req",   32'(bus.dmem_req_o), 32'd0);
    chk("rst_we",    32'(bus.dmem_we_o), 32'd0);
    chk("rst_be",    32'(bus.dmem_be_o), 32'd0);
    chk("rst_ldata", bus.load_data_o, 32'h0);
    chk("rst_addr",  bus.dmem_addr_o, 32'h0);
    chk("rst_wdata", bus.dmem_wdata_o, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    do_access("sb",      1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    do_access("sh",      1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234_BEEF, 2, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_access("sw",      1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 0, 32'h0, 4'b1111, 32'h1234_5678, 32'h0);
    do_access("ldst_sb", 1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_003C, 0, 32'h0, 4'b0010, 32'h3C3C_3C3C, 32'h0);
    do_access("lb",      1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 32'h0080_0000, 4'b0100, 32'h0, 32'hFFFF_FF80);
    do_access("lbu",     1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 32'h0080_0000, 4'b0100, 32'h0, 32'h0000_0080);
    do_access("lh",      1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h0, 0, 32'h8001_FFFF, 4'b1100, 32'h0, 32'hFFFF_8001);
    do_access("lhu",     1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0, 0, 32'h8001_FFFF, 4'b1100, 32'h0, 32'h0000_8001);
    do_access("lh_lo",   1'b1, 1'b0, 3'b001, 32'h0000_3000, 32'h0, 0, 32'h8001_FFFF, 4'b0011, 32'h0, 32'hFFFF_FFFF);
    do_access("lw",      1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

    do_illegal("lw_misal", 1'b1, 1'b0, 3'b010, 32'h0000_0001);
    do_illegal("lh_misal", 1'b1, 1'b0, 3'b001, 32'h0000_3003);
    do_illegal("f3_011",   1'b1, 1'b0, 3'b011, 32'h0000_0000);
    do_illegal("sbu",      1'b0, 1'b1, 3'b100, 32'h0000_0000);

    // Grant on the last cycle before the timeout must win.
    do_access("sw_late_gnt", 1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'hA5A5_0F0F, 3, 32'h0, 4'b1111, 32'hA5A5_0F0F, 32'h0);

    drive(1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'h1111_2222);
    sb_q.push_back('{"tmo_req", 1'b1, model_ld});
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req_high", 32'(bus.dmem_req_o), 32'd1);
      chk("tmo_req_nodone", 32'(bus.done_o), 32'd0);
      step();
    end
    chk("tmo_req_done", 32'(bus.done_o), 32'd1);
    chk("tmo_req_dropped", 32'(bus.dmem_req_o), 32'd0);
    step();

    drive(1'b1, 1'b0, 3'b010, 32'h0000_0084, 32'h0);
    sb_q.push_back('{"tmo_wait", 1'b1, model_ld});
    step();
    idle_inputs();
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_wait_busy", 32'(bus.busy_o), 32'd1);
      chk("tmo_wait_nodone", 32'(bus.done_o), 32'd0);
      step();
    end
    chk("tmo_wait_done", 32'(bus.done_o), 32'd1);
    step();

    drive(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    step();
    idle_inputs();
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i = 1'b0;
    chk("rstw_in_wait", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_busy",  32'(bus.busy_o), 32'd0);
    chk("rstw_done",  32'(bus.done_o), 32'd0);
    chk("rstw_req",   32'(bus.dmem_req_o), 32'd0);
    chk("rstw_be",    32'(bus.dmem_be_o), 32'd0);
    chk("rstw_ldata", bus.load_data_o, 32'h0);
    model_ld = 32'h0;
    step();
    rst_n = 1'b1;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hDEAD_BEEF;
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("rstw_post_busy", 32'(bus.busy_o), 32'd0);
    chk("rstw_post_done", 32'(bus.done_o), 32'd0);
    step();
    chk("rstw_post_ldata", bus.load_data_o, 32'h0);

    do_access("lbu_after_rst", 1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 32'h0080_0000, 4'b0100, 32'h0, 32'h0000_0080);

    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
